gcd_job_sequencer: RTL and testbench

Initiator side of the gcd_calc start/done handshake. Buffers operand pairs from an upstream valid/ready stream and issues them one at a time to a gcd_calc instance. Captures each result and returns it with its operands on a downstream valid/ready stream. Handles the zero-operand cases locally and times out a stuck engine.

---
 rtl/gcd_job_sequencer_if.sv | 41 ++++
 rtl/gcd_job_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_gcd_job_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_job_sequencer_if.sv
// Bundle of the gcd_job_sequencer handshake/bus signals.
//   upstream  : in_valid, in_ready, in_p, in_q
//   engine    : gcd_start, gcd_p, gcd_q, gcd_r, gcd_done
//   downstream: out_valid, out_ready, out_p, out_q, out_r, out_err
//   status    : busy
// master = the sequencer itself, slave = its environment (source, engine, sink).
interface gcd_job_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_p;
    logic [WIDTH-1:0] in_q;

    logic             gcd_start;
    logic [WIDTH-1:0] gcd_p;
    logic [WIDTH-1:0] gcd_q;
    logic [WIDTH-1:0] gcd_r;
    logic             gcd_done;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_p;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_r;
    logic             out_err;

    logic             busy;

    modport master (
        input  in_valid, in_p, in_q, gcd_r, gcd_done, out_ready,
        output in_ready, gcd_start, gcd_p, gcd_q,
               out_valid, out_p, out_q, out_r, out_err, busy
    );

    modport slave (
        output in_valid, in_p, in_q, gcd_r, gcd_done, out_ready,
        input  in_ready, gcd_start, gcd_p, gcd_q,
               out_valid, out_p, out_q, out_r, out_err, busy
    );
endinterface

// File: rtl/gcd_job_sequencer.sv
// Initiator for a gcd_calc engine: queues operand pairs from a valid/ready
// stream, issues them one at a time over the start/done handshake, and
// returns {p, q, r, err} on a valid/ready output stream. Zero operands are
// resolved locally; a stuck engine is aborted after TIMEOUT cycles.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset
//   bus  - gcd_job_sequencer_if.master (upstream, engine, downstream, busy)
module gcd_job_sequencer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst,
    gcd_job_sequencer_if.master bus
);
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, PRESENT} state_t;

    // Job FIFO
    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]    count_q, count_d;
    logic [2*WIDTH-1:0] head;
    logic               push, pop;

    // FSM and registered outputs
    state_t             state_q, state_d;
    logic               op_vld_q, op_vld_d;
    logic [WIDTH-1:0]   op_p_q, op_p_d, op_q_q, op_q_d;
    logic [TW-1:0]      tmo_q, tmo_d, tmo_inc;
    logic               start_q, start_d;
    logic [WIDTH-1:0]   gp_q, gp_d, gq_q, gq_d;
    logic               ov_q, ov_d;
    logic [WIDTH-1:0]   outp_q, outp_d, outq_q, outq_d, outr_q, outr_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;

    assign head = mem[rd_ptr_q];
    assign push = bus.in_valid & in_ready_q;

    assign bus.in_ready  = in_ready_q;
    assign bus.gcd_start = start_q;
    assign bus.gcd_p     = gp_q;
    assign bus.gcd_q     = gq_q;
    assign bus.out_valid = ov_q;
    assign bus.out_p     = outp_q;
    assign bus.out_q     = outq_q;
    assign bus.out_r     = outr_q;
    assign bus.out_err   = err_q;
    assign bus.busy      = busy_q;

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        op_vld_d = op_vld_q;
        op_p_d = op_p_q;
        op_q_d = op_q_q;
        tmo_d = tmo_q;
        start_d = start_q;
        gp_d = gp_q;
        gq_d = gq_q;
        ov_d = ov_q;
        outp_d = outp_q;
        outq_d = outq_q;
        outr_d = outr_q;
        err_d = err_q;
        pop = 1'b0;
        // Saturating increment of the engine watchdog
        tmo_inc = (tmo_q == TW'(TIMEOUT)) ? tmo_q : tmo_q + TW'(1);

        case (state_q)
            IDLE: begin
                if (op_vld_q) begin
                    if ((op_p_q != '0) && (op_q_q != '0)) begin
                        // Never raise start while the engine still shows done
                        // (e.g. after a reset that cut a job short).
                        if (!bus.gcd_done) begin
                            start_d  = 1'b1;
                            gp_d     = op_p_q;
                            gq_d     = op_q_q;
                            tmo_d    = '0;
                            op_vld_d = 1'b0;
                            state_d  = ISSUE;
                        end
                    end else begin
                        outp_d   = op_p_q;
                        outq_d   = op_q_q;
                        outr_d   = (op_p_q == '0) ? op_q_q : op_p_q;
                        err_d    = (op_p_q == '0) && (op_q_q == '0);
                        ov_d     = 1'b1;
                        op_vld_d = 1'b0;
                        state_d  = PRESENT;
                    end
                end else if (count_q != '0) begin
                    pop      = 1'b1;
                    op_p_d   = head[2*WIDTH-1:WIDTH];
                    op_q_d   = head[WIDTH-1:0];
                    op_vld_d = 1'b1;
                end
            end
            ISSUE: begin
                tmo_d = tmo_inc;
                if (bus.gcd_done) begin
                    outp_d  = gp_q;
                    outq_d  = gq_q;
                    outr_d  = bus.gcd_r;
                    err_d   = 1'b0;
                    start_d = 1'b0;
                    state_d = RELEASE;
                end else if (tmo_inc == TW'(TIMEOUT)) begin
                    outp_d  = gp_q;
                    outq_d  = gq_q;
                    outr_d  = '0;
                    err_d   = 1'b1;
                    start_d = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!bus.gcd_done) begin
                    ov_d    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNTW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNTW'(1);
        end
        in_ready_d = (count_d != CNTW'(DEPTH));
        busy_d     = (state_d != IDLE) || op_vld_d || (count_d != '0);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            op_vld_q   <= 1'b0;
            op_p_q     <= '0;
            op_q_q     <= '0;
            tmo_q      <= '0;
            start_q    <= 1'b0;
            gp_q       <= '0;
            gq_q       <= '0;
            ov_q       <= 1'b0;
            outp_q     <= '0;
            outq_q     <= '0;
            outr_q     <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_vld_q   <= op_vld_d;
            op_p_q     <= op_p_d;
            op_q_q     <= op_q_d;
            tmo_q      <= tmo_d;
            start_q    <= start_d;
            gp_q       <= gp_d;
            gq_q       <= gq_d;
            ov_q       <= ov_d;
            outp_q     <= outp_d;
            outq_q     <= outq_d;
            outr_q     <= outr_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
            count_q    <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers gate them
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr_q] <= {bus.in_p, bus.in_q};
        end
    end
endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Directed bench for gcd_job_sequencer with a behavioural gcd engine and a
// scoreboard of expected {p, q, r, err} results checked at each handshake.
module tb_gcd_job_sequencer;
    localparam int unsigned W  = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned TO = 15;
    localparam int ENG_LAT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gcd_job_sequencer_if #(.WIDTH(W)) bus ();

    gcd_job_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [W-1:0] p;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_results = 0;
    int   eng_mode = 0;   // 0 responsive, 1 never done, 2 done forced high
    int   eng_cnt = 0;
    bit   start_seen = 1'b0;

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] t;
        x = a;
        y = b;
        for (int i = 0; i < 64; i++) begin
            if (y != '0) begin
                t = x % y;
                x = y;
                y = t;
            end
        end
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Engine model: done after ENG_LAT cycles of start, held until start drops
    always @(negedge clk) begin
        if (eng_mode == 2) begin
            bus.gcd_done = 1'b1;
        end else if (eng_mode == 1 || !rst) begin
            bus.gcd_done = 1'b0;
            bus.gcd_r = '0;
            eng_cnt = 0;
        end else if (bus.gcd_start && !bus.gcd_done) begin
            if (eng_cnt + 1 >= ENG_LAT) begin
                bus.gcd_done = 1'b1;
                bus.gcd_r = gcd_ref(bus.gcd_p, bus.gcd_q);
                eng_cnt = 0;
            end else begin
                eng_cnt++;
            end
        end else if (!bus.gcd_start) begin
            bus.gcd_done = 1'b0;
            eng_cnt = 0;
        end
    end

    // Output monitor / scoreboard compare
    always @(negedge clk) begin
        if (bus.gcd_start) start_seen = 1'b1;
        if (rst && bus.out_valid && bus.out_ready) begin
            n_results++;
            chk("result_expected", 32'(sb.size() != 0), 32'(1));
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("out_p", 32'(bus.out_p), 32'(mon_e.p));
                chk("out_q", 32'(bus.out_q), 32'(mon_e.q));
                chk("out_r", 32'(bus.out_r), 32'(mon_e.r));
                chk("out_err", 32'(bus.out_err), 32'(mon_e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 normal, 1 engine will time out, 2 result discarded (no expectation)
    task automatic push_job(input logic [W-1:0] p, input logic [W-1:0] q, input int kind);
        exp_t x;
        int k;
        k = 0;
        while (!bus.in_ready && k < 200) begin
            tick();
            k++;
        end
        if (!bus.in_ready) chk("in_ready_wait", 32'(bus.in_ready), 32'(1));
        x.p = p;
        x.q = q;
        x.err = 1'b0;
        if (p == 0 && q == 0) begin
            x.r = '0;
            x.err = 1'b1;
        end else if (p == 0) begin
            x.r = q;
        end else if (q == 0) begin
            x.r = p;
        end else if (kind == 1) begin
            x.r = '0;
            x.err = 1'b1;
        end else begin
            x.r = gcd_ref(p, q);
        end
        if (kind != 2) sb.push_back(x);
        bus.in_valid = 1'b1;
        bus.in_p = p;
        bus.in_q = q;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_start();
        int k;
        k = 0;
        while (!bus.gcd_start && k < 100) begin
            tick();
            k++;
        end
        chk("start_rise", 32'(bus.gcd_start), 32'(1));
    endtask

    task automatic count_start_high(output int n);
        n = 0;
        while (bus.gcd_start && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic lat_to_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((sb.size() != 0 || bus.busy || bus.out_valid) && k < 500) begin
            tick();
            k++;
        end
        chk(tag, 32'(sb.size()), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r0;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_p = '0;
        bus.in_q = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_gcd_start", 32'(bus.gcd_start), 32'(0));
        chk("rst_gcd_p", 32'(bus.gcd_p), 32'(0));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_out_r", 32'(bus.out_r), 32'(0));
        chk("rst_out_err", 32'(bus.out_err), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        rst = 1'b1;
        tick();
        chk("in_ready_after_rst", 32'(bus.in_ready), 32'(1));

        // Engine job (6,4) -> 2, start timing around the pop
        push_job(8'd6, 8'd4, 0);
        chk("t1_start_low_push", 32'(bus.gcd_start), 32'(0));
        tick();
        chk("t1_start_low_pop", 32'(bus.gcd_start), 32'(0));
        tick();
        chk("t1_start_high", 32'(bus.gcd_start), 32'(1));
        chk("t1_gcd_p", 32'(bus.gcd_p), 32'(6));
        chk("t1_gcd_q", 32'(bus.gcd_q), 32'(4));
        count_start_high(n);
        chk("t1_start_cycles", 32'(n), 32'(ENG_LAT));
        drain("t1_drain");

        // Single-zero bypass: 2-cycle latency, engine untouched
        start_seen = 1'b0;
        push_job(8'd0, 8'd9, 0);
        lat_to_valid(n);
        chk("t2a_latency", 32'(n), 32'(2));
        push_job(8'd12, 8'd0, 0);
        lat_to_valid(n);
        chk("t2b_latency", 32'(n), 32'(2));
        drain("t2_drain");
        chk("t2_no_start", 32'(start_seen), 32'(0));

        // Both zero -> error result, engine untouched
        push_job(8'd0, 8'd0, 0);
        drain("t3_drain");
        chk("t3_no_start", 32'(start_seen), 32'(0));

        // Stuck engine: abort after exactly TO cycles, then a normal job
        eng_mode = 1;
        push_job(8'd8, 8'd12, 1);
        wait_start();
        count_start_high(n);
        chk("t4_start_cycles", 32'(n), 32'(TO));
        eng_mode = 0;
        push_job(8'd9, 8'd6, 0);
        drain("t4_drain");

        // Back-pressure: FIFO fills behind the presenting job, then drains in order
        bus.out_ready = 1'b0;
        push_job(8'd48, 8'd18, 0);
        push_job(8'd12, 8'd8, 0);
        push_job(8'd35, 8'd21, 0);
        push_job(8'd0, 8'd5, 0);
        push_job(8'd27, 8'd9, 0);
        repeat (15) tick();
        chk("t5_presenting", 32'(bus.out_valid), 32'(1));
        chk("t5_in_ready_low", 32'(bus.in_ready), 32'(0));
        chk("t5_busy", 32'(bus.busy), 32'(1));
        r0 = n_results;
        bus.out_ready = 1'b1;
        push_job(8'd100, 8'd75, 0);
        drain("t5_drain");
        chk("t5_result_count", 32'(n_results - r0), 32'(6));

        // Reset mid-ISSUE with done held high
        eng_mode = 1;
        push_job(8'd9, 8'd6, 2);
        wait_start();
        eng_mode = 2;
        rst = 1'b0;
        tick();
        chk("t6_rst_start", 32'(bus.gcd_start), 32'(0));
        chk("t6_rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("t6_rst_busy", 32'(bus.busy), 32'(0));
        rst = 1'b1;
        tick();
        chk("t6_in_ready", 32'(bus.in_ready), 32'(1));
        chk("t6_busy_idle", 32'(bus.busy), 32'(0));
        start_seen = 1'b0;
        push_job(8'd20, 8'd15, 0);
        repeat (6) tick();
        chk("t6_start_held_off", 32'(start_seen), 32'(0));
        eng_mode = 0;
        drain("t6_drain");
        chk("t6_start_after_release", 32'(start_seen), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
